// File: rtl/axis_bram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axis_bram_pkg (package)
//  Description : Items shared by the AXI-Stream to BRAM writer.
//                - state_t            : writer FSM states (IDLE/RECV/WRITE/DONE)
//                - clogb2()           : ceiling log2, never less than 1
//                - sub_words_per_beat : R = stream width / BRAM word width
//  Revision    : 1.0 - initial release
// ============================================================================
package axis_bram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Bits needed to index 'value' items; a single item still gets one bit
    // so that index registers never collapse to zero width.
    function automatic int clogb2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Number of BRAM words carried by one stream beat.
    function automatic int sub_words_per_beat(input int axis_w, input int bram_w);
        return axis_w / bram_w;
    endfunction

endpackage : axis_bram_pkg
`default_nettype wire

// File: rtl/axis_bram_writer_if.sv
`default_nettype none
// ============================================================================
//  Module      : axis_bram_writer_if (interface)
//  Description : Bundles the writer's stream, BRAM, control and depth-FIFO
//                signals.
//                slave  modport : the writer (consumes AXIS, drives BRAM)
//                master modport : the environment around the writer
//                Optional AXIS_TKEEP exists when AXIS_BRAM_WRITER_TKEEP_EN
//                is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface axis_bram_writer_if #(
    parameter int AXIS_DATA_WIDTH = 64,
    parameter int BRAM_DATA_WIDTH = 32,
    parameter int BRAM_ADDR_WIDTH = 10
) ();

    // Control
    logic                           CTRL_ALLOW;
    logic                           CTRL_FINISHED;
    // AXI-Stream
    logic [AXIS_DATA_WIDTH-1:0]     AXIS_TDATA;
    logic                           AXIS_TVALID;
    logic                           AXIS_TLAST;
    logic                           AXIS_TREADY;
`ifdef AXIS_BRAM_WRITER_TKEEP_EN
    logic [AXIS_DATA_WIDTH/8-1:0]   AXIS_TKEEP;
`endif
    // BRAM write port
    logic [BRAM_ADDR_WIDTH-1:0]     BRAM_ADDR;
    logic [BRAM_DATA_WIDTH-1:0]     BRAM_DOUT;
    logic [BRAM_DATA_WIDTH/8-1:0]   BRAM_WE;
    logic                           BRAM_EN;
    // Depth FIFO write port
    logic [31:0]                    DATA_DEPTH;
    logic                           DATA_DEPTH_WRITE;
    logic                           DATA_DEPTH_FULL;
    // Status
    logic                           OVERFLOW;

    modport slave (
        input  CTRL_ALLOW,
        input  AXIS_TDATA, AXIS_TVALID, AXIS_TLAST,
`ifdef AXIS_BRAM_WRITER_TKEEP_EN
        input  AXIS_TKEEP,
`endif
        input  DATA_DEPTH_FULL,
        output CTRL_FINISHED, AXIS_TREADY,
        output BRAM_ADDR, BRAM_DOUT, BRAM_WE, BRAM_EN,
        output DATA_DEPTH, DATA_DEPTH_WRITE, OVERFLOW
    );

    modport master (
        output CTRL_ALLOW,
        output AXIS_TDATA, AXIS_TVALID, AXIS_TLAST,
`ifdef AXIS_BRAM_WRITER_TKEEP_EN
        output AXIS_TKEEP,
`endif
        output DATA_DEPTH_FULL,
        input  CTRL_FINISHED, AXIS_TREADY,
        input  BRAM_ADDR, BRAM_DOUT, BRAM_WE, BRAM_EN,
        input  DATA_DEPTH, DATA_DEPTH_WRITE, OVERFLOW
    );

endinterface : axis_bram_writer_if
`default_nettype wire

// File: rtl/axis_beat_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : axis_beat_serializer
//  Description : Holds one accepted stream beat and presents it one BRAM
//                word at a time, least-significant word first.
//                clk, rst      : clock, synchronous active-high reset
//                load          : capture beat_data/beat_keep/beat_last
//                advance       : step to the next sub-word
//                sub_word      : current sub-word
//                sub_be        : byte enables (keep bits) of that sub-word
//                last_sub      : current sub-word is the beat's last one
//                beat_is_last  : latched TLAST of the held beat
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_beat_serializer
    import axis_bram_pkg::*;
#(
    parameter int AXIS_DATA_WIDTH = 64,
    parameter int BRAM_DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load,
    input  logic                          advance,
    input  logic [AXIS_DATA_WIDTH-1:0]    beat_data,
    input  logic [AXIS_DATA_WIDTH/8-1:0]  beat_keep,
    input  logic                          beat_last,
    output logic [BRAM_DATA_WIDTH-1:0]    sub_word,
    output logic [BRAM_DATA_WIDTH/8-1:0]  sub_be,
    output logic                          last_sub,
    output logic                          beat_is_last
);

    localparam int R     = sub_words_per_beat(AXIS_DATA_WIDTH, BRAM_DATA_WIDTH);
    localparam int IDX_W = clogb2(R);
    localparam int BE_W  = BRAM_DATA_WIDTH / 8;

    logic [AXIS_DATA_WIDTH-1:0]   r_data;
    logic [AXIS_DATA_WIDTH/8-1:0] r_keep;
    logic                         r_last;
    logic [IDX_W-1:0]             r_idx;

    // The beat is shifted down after each sub-word, so the current word is
    // always in the low bits and no wide multiplexer is needed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
            r_keep <= '0;
            r_last <= 1'b0;
            r_idx  <= '0;
        end else if (load) begin
            r_data <= beat_data;
            r_keep <= beat_keep;
            r_last <= beat_last;
            r_idx  <= '0;
        end else if (advance && !last_sub) begin
            r_data <= r_data >> BRAM_DATA_WIDTH;
            r_keep <= r_keep >> BE_W;
            r_idx  <= r_idx + 1'b1;
        end
    end

    assign sub_word     = r_data[BRAM_DATA_WIDTH-1:0];
    assign sub_be       = r_keep[BE_W-1:0];
    assign last_sub     = (r_idx == IDX_W'(R - 1));
    assign beat_is_last = r_last;

endmodule : axis_beat_serializer
`default_nettype wire

// File: rtl/axis_bram_writer.sv
`default_nettype none
// ============================================================================
//  Module      : axis_bram_writer
//  Description : Receives an AXI-Stream frame and writes it into a BRAM
//                buffer one BRAM word per cycle, then pushes the number of
//                words written into a depth FIFO.
//                ACC_CLK, ARESET : clock, synchronous active-high reset
//                bus (slave)     : CTRL_ALLOW/CTRL_FINISHED, AXIS_T*,
//                                  BRAM_*, DATA_DEPTH*, OVERFLOW
//                Words beyond BRAM_DATA_DEPTH are dropped, OVERFLOW is set
//                and the stream is drained until TLAST.
//                Define AXIS_BRAM_WRITER_TKEEP_EN to honour AXIS_TKEEP:
//                sub-words with no kept bytes are skipped, and BRAM_WE
//                follows the kept bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_bram_writer
    import axis_bram_pkg::*;
#(
    parameter int AXIS_DATA_WIDTH = 64,
    parameter int BRAM_DATA_WIDTH = 32,
    parameter int BRAM_ADDR_WIDTH = 10,
    parameter int BRAM_DATA_DEPTH = 1024
) (
    input  logic              ACC_CLK,
    input  logic              ARESET,
    axis_bram_writer_if.slave bus
);

    localparam int BE_W   = BRAM_DATA_WIDTH / 8;
    localparam int KEEP_W = AXIS_DATA_WIDTH / 8;

    state_t                      r_state;
    state_t                      w_state_next;
    logic [31:0]                 r_word_cnt;
    logic                        r_overflow;

    logic [KEEP_W-1:0]           w_beat_keep;
    logic [BRAM_DATA_WIDTH-1:0]  w_sub_word;
    logic [BE_W-1:0]             w_sub_be;
    logic                        w_last_sub;
    logic                        w_beat_last;
    logic                        w_has_bytes;
    logic                        w_room;
    logic                        w_accept;
    logic                        w_write;
    logic                        w_overflow_hit;
    logic                        w_push;

`ifdef AXIS_BRAM_WRITER_TKEEP_EN
    assign w_beat_keep = bus.AXIS_TKEEP;
`else
    assign w_beat_keep = '1;
`endif

    axis_beat_serializer #(
        .AXIS_DATA_WIDTH (AXIS_DATA_WIDTH),
        .BRAM_DATA_WIDTH (BRAM_DATA_WIDTH)
    ) u_serializer (
        .clk          (ACC_CLK),
        .rst          (ARESET),
        .load         (w_accept),
        .advance      (r_state == ST_WRITE),
        .beat_data    (bus.AXIS_TDATA),
        .beat_keep    (w_beat_keep),
        .beat_last    (bus.AXIS_TLAST),
        .sub_word     (w_sub_word),
        .sub_be       (w_sub_be),
        .last_sub     (w_last_sub),
        .beat_is_last (w_beat_last)
    );

    assign w_has_bytes = |w_sub_be;
    assign w_room      = (r_word_cnt < 32'(BRAM_DATA_DEPTH));

    always_comb begin
        w_state_next   = r_state;
        w_accept       = 1'b0;
        w_write        = 1'b0;
        w_overflow_hit = 1'b0;
        w_push         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.CTRL_ALLOW) begin
                    w_state_next = ST_RECV;
                end
            end
            ST_RECV: begin
                if (bus.AXIS_TVALID) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // A sub-word with data but no room marks overflow; the beat
                // still takes its cycle so the stream keeps draining.
                w_write        = w_has_bytes && w_room;
                w_overflow_hit = w_has_bytes && !w_room;
                if (w_last_sub) begin
                    w_state_next = w_beat_last ? ST_DONE : ST_RECV;
                end
            end
            ST_DONE: begin
                if (!bus.DATA_DEPTH_FULL) begin
                    w_push       = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge ACC_CLK) begin
        if (ARESET) begin
            r_state    <= ST_IDLE;
            r_word_cnt <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_IDLE && bus.CTRL_ALLOW) begin
                r_overflow <= 1'b0;
                r_word_cnt <= '0;
            end
            if (w_write) begin
                r_word_cnt <= r_word_cnt + 32'd1;
            end
            if (w_overflow_hit) begin
                r_overflow <= 1'b1;
            end
            if (w_push) begin
                r_word_cnt <= '0;
            end
        end
    end

    assign bus.AXIS_TREADY      = (r_state == ST_RECV);
    assign bus.BRAM_EN          = w_write;
    assign bus.BRAM_WE          = w_write ? w_sub_be : '0;
    assign bus.BRAM_ADDR        = w_write ? r_word_cnt[BRAM_ADDR_WIDTH-1:0] : '0;
    assign bus.BRAM_DOUT        = w_write ? w_sub_word : '0;
    assign bus.DATA_DEPTH       = (r_state == ST_DONE) ? r_word_cnt : '0;
    assign bus.DATA_DEPTH_WRITE = w_push;
    assign bus.CTRL_FINISHED    = w_push;
    assign bus.OVERFLOW         = r_overflow;

endmodule : axis_bram_writer
`default_nettype wire
